// File: rtl/hazard_pkg.sv
// Shared constants, types and helpers for the hazard/scoreboard block.
package hazard_pkg;

  // Forwarding select value meaning "take the operand from the register file".
  localparam int unsigned FWD_RF = 0;

  // Default architectural register count of the core.
  localparam int unsigned DEF_NREGS = 32;

  // Register index for the default register count.
  typedef logic [$clog2(DEF_NREGS)-1:0] reg_idx_t;

  // Width of a forwarding select: register file plus one code per source.
  function automatic int unsigned fwd_sel_width(input int unsigned nfwd);
    return $clog2(nfwd + 1);
  endfunction

endpackage

// File: rtl/pending_scoreboard.sv
// Register scoreboard for variable-latency ops: pending bitmap, outstanding
// counter and a sticky error for completions that match nothing pending.
module pending_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NREGS  = 32,
  parameter int unsigned MAXOUT = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         issue,
  input  logic [$clog2(NREGS)-1:0]     issue_rd,
  input  logic                         done_valid,
  input  logic [$clog2(NREGS)-1:0]     done_rd,
  output logic [NREGS-1:0]             pending,
  output logic [$clog2(MAXOUT+1)-1:0]  count,
  output logic                         sb_error
);

  localparam int unsigned CW = $clog2(MAXOUT + 1);

  logic [NREGS-1:0] pending_q, pending_d;
  logic [CW-1:0]    count_q, count_d;
  logic             sb_error_q, sb_error_d;
  logic             set_en, done_ok, done_bad;

  assign set_en   = issue && (issue_rd != '0);
  assign done_ok  = done_valid && (done_rd != '0) && pending_q[done_rd];
  assign done_bad = done_valid && (done_rd != '0) && !pending_q[done_rd];

  // Next-state: clear on completion first, then set on issue. With the
  // completion bypass both can hit the same index, and the new op wins.
  always_comb begin
    pending_d = pending_q;
    if (done_ok) pending_d[done_rd] = 1'b0;
    if (set_en)  pending_d[issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Outstanding counter: saturating, unchanged when issue and completion coincide.
  always_comb begin
    count_d = count_q;
    if (issue && !done_ok) begin
      if (count_q != CW'(MAXOUT)) count_d = count_q + CW'(1);
    end else if (done_ok && !issue) begin
      if (count_q != '0) count_d = count_q - CW'(1);
    end
  end

  // Sticky error for a completion that targets a non-pending register.
  always_comb begin
    sb_error_d = sb_error_q | done_bad;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      count_q    <= '0;
      sb_error_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      count_q    <= count_d;
      sb_error_q <= sb_error_d;
    end
  end

  assign pending  = pending_q;
  assign count    = count_q;
  assign sb_error = sb_error_q;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard controller: N-source forwarding, load-use stall, branch
// flush and scoreboard-based issue stall for variable-latency units.
// Optional macro HAZARD_SB_DONE_BYPASS_EN lets a completion release its
// dependents in the same cycle instead of one cycle later.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NFWD   = 2,
  parameter int unsigned MAXOUT = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                validD,
  input  logic [$clog2(NREGS)-1:0]            rs1D,
  input  logic [$clog2(NREGS)-1:0]            rs2D,
  input  logic [$clog2(NREGS)-1:0]            rdD,
  input  logic                                useRs1D,
  input  logic                                useRs2D,
  input  logic                                regWriteD,
  input  logic                                longOpD,
  input  logic [$clog2(NREGS)-1:0]            rs1E,
  input  logic [$clog2(NREGS)-1:0]            rs2E,
  input  logic [$clog2(NREGS)-1:0]            rdE,
  input  logic                                resultSrcE,
  input  logic                                pcSrcE,
  input  logic [NFWD*$clog2(NREGS)-1:0]       fwdRd,
  input  logic [NFWD-1:0]                     fwdWe,
  input  logic                                doneValid,
  input  logic [$clog2(NREGS)-1:0]            doneRd,
  output logic                                stallF,
  output logic                                stallD,
  output logic                                flushD,
  output logic                                flushE,
  output logic [fwd_sel_width(NFWD)-1:0]      forwardAE,
  output logic [fwd_sel_width(NFWD)-1:0]      forwardBE,
  output logic [NREGS-1:0]                    pending,
  output logic                                sbError
);

  localparam int unsigned IW = $clog2(NREGS);
  localparam int unsigned FW = fwd_sel_width(NFWD);
  localparam int unsigned CW = $clog2(MAXOUT + 1);

  logic [NREGS-1:0] pend_view;
  logic [CW-1:0]    count;
  logic [CW:0]      count_ext;
  logic             sb_full, load_use, sb_stall, hazard, issue;

  // Forwarding: scan oldest to youngest so the lowest matching index wins.
  always_comb begin
    forwardAE = FW'(FWD_RF);
    forwardBE = FW'(FWD_RF);
    for (int i = int'(NFWD) - 1; i >= 0; i--) begin
      if (fwdWe[i] && (fwdRd[i*IW +: IW] == rs1E) && (rs1E != '0)) forwardAE = FW'(i + 1);
      if (fwdWe[i] && (fwdRd[i*IW +: IW] == rs2E) && (rs2E != '0)) forwardBE = FW'(i + 1);
    end
  end

  assign count_ext = {1'b0, count};

`ifdef HAZARD_SB_DONE_BYPASS_EN
  // Scoreboard view with this cycle's completion already retired.
  always_comb begin
    pend_view = pending;
    if (doneValid) pend_view[doneRd] = 1'b0;
  end
  // Full test against count minus the completing op (no underflow form).
  assign sb_full = (count_ext == ((CW+1)'(MAXOUT) + {{CW{1'b0}}, doneValid}));
`else
  // Scoreboard view is the registered state only.
  always_comb begin
    pend_view = pending;
  end
  assign sb_full = (count_ext == (CW+1)'(MAXOUT));
`endif

  // Stall/flush decision; a redirect overrides every stall.
  always_comb begin
    load_use = resultSrcE && (rdE != '0) &&
               ((useRs1D && (rs1D == rdE)) || (useRs2D && (rs2D == rdE)));
    sb_stall = validD && ((useRs1D && pend_view[rs1D]) || (useRs2D && pend_view[rs2D]) ||
                          (regWriteD && pend_view[rdD]) || (longOpD && sb_full));
    hazard   = (load_use || sb_stall) && !pcSrcE;
    stallF   = hazard;
    stallD   = hazard;
    flushE   = hazard || pcSrcE;
    flushD   = pcSrcE;
    issue    = validD && longOpD && regWriteD && (rdD != '0) && !hazard && !pcSrcE;
  end

  pending_scoreboard #(
    .NREGS  (NREGS),
    .MAXOUT (MAXOUT)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue      (issue),
    .issue_rd   (rdD),
    .done_valid (doneValid),
    .done_rd    (doneRd),
    .pending    (pending),
    .count      (count),
    .sb_error   (sbError)
  );

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench for hazard_scoreboard_unit (default parameters).
module tb_hazard_scoreboard_unit;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic validD, useRs1D, useRs2D, regWriteD, longOpD, resultSrcE, pcSrcE, doneValid;
  reg_idx_t rs1D, rs2D, rdD, rs1E, rs2E, rdE, doneRd;
  logic [9:0]  fwdRd;
  logic [1:0]  fwdWe;
  logic stallF, stallD, flushD, flushE, sbError;
  logic [1:0]  forwardAE, forwardBE;
  logic [31:0] pending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(.NREGS(32), .NFWD(2), .MAXOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .validD(validD), .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD),
    .useRs1D(useRs1D), .useRs2D(useRs2D), .regWriteD(regWriteD), .longOpD(longOpD),
    .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .resultSrcE(resultSrcE), .pcSrcE(pcSrcE),
    .fwdRd(fwdRd), .fwdWe(fwdWe), .doneValid(doneValid), .doneRd(doneRd),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .forwardAE(forwardAE), .forwardBE(forwardBE), .pending(pending), .sbError(sbError)
  );

  typedef struct {
    logic       vd, u1, u2, rsrc, pcs;
    logic [4:0] r1d, r2d, r1e, r2e, rde;
    logic [9:0] frd;
    logic [1:0] fwe;
    logic [3:0] ctrl;  // {stallF, stallD, flushD, flushE}
    logic [1:0] fa, fb;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    validD = 0; useRs1D = 0; useRs2D = 0; regWriteD = 0; longOpD = 0;
    resultSrcE = 0; pcSrcE = 0; doneValid = 0;
    rs1D = '0; rs2D = '0; rdD = '0; rs1E = '0; rs2E = '0; rdE = '0; doneRd = '0;
    fwdRd = '0; fwdWe = '0;
  endtask

  // Advance one clock; inputs are then changed #1 after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic long_op(input logic [4:0] rd);
    validD = 1; longOpD = 1; regWriteD = 1; rdD = rd;
  endtask

  initial begin
    //        vd u1 u2 rs pc r1d r2d r1e r2e rde frd                 fwe    ctrl     fa fb
    vecs[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'd0,              2'b00, 4'b0000, 0, 0};
    vecs[1] = '{0, 0, 0, 0, 0, 0, 0, 5, 0, 0, {5'd5, 5'd5},       2'b11, 4'b0000, 1, 0};
    vecs[2] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'd0,              2'b11, 4'b0000, 0, 0};
    vecs[3] = '{0, 0, 0, 0, 0, 0, 0, 5, 3, 0, {5'd5, 5'd3},       2'b10, 4'b0000, 2, 0};
    vecs[4] = '{0, 0, 0, 0, 0, 0, 0, 5, 3, 0, {5'd5, 5'd3},       2'b11, 4'b0000, 2, 1};
    vecs[5] = '{1, 0, 1, 1, 0, 0, 7, 0, 0, 7, 10'd0,              2'b00, 4'b1101, 0, 0};
    vecs[6] = '{1, 0, 1, 1, 1, 0, 7, 0, 0, 7, 10'd0,              2'b00, 4'b0011, 0, 0};
    vecs[7] = '{1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 10'd0,              2'b00, 4'b0000, 0, 0};
    vecs[8] = '{1, 0, 0, 1, 0, 7, 0, 0, 0, 7, 10'd0,              2'b00, 4'b0000, 0, 0};
    vecs[9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 10'd0,              2'b00, 4'b0011, 0, 0};

    clear_inputs();
    rst_n = 0;
    #12;
    chk("reset_pending", pending, 32'h0);
    chk("reset_sberror", {31'd0, sbError}, 32'd0);
    chk("reset_count", {29'd0, dut.u_sb.count}, 32'd0);
    rst_n = 1;
    step();

    // Combinational vectors (no long ops, so no state change).
    for (int i = 0; i < 10; i++) begin
      clear_inputs();
      validD = vecs[i].vd; useRs1D = vecs[i].u1; useRs2D = vecs[i].u2;
      resultSrcE = vecs[i].rsrc; pcSrcE = vecs[i].pcs;
      rs1D = vecs[i].r1d; rs2D = vecs[i].r2d; rs1E = vecs[i].r1e; rs2E = vecs[i].r2e;
      rdE = vecs[i].rde; fwdRd = vecs[i].frd; fwdWe = vecs[i].fwe;
      #1;
      chk($sformatf("vec%0d_ctrl", i), {28'd0, stallF, stallD, flushD, flushE},
          {28'd0, vecs[i].ctrl});
      chk($sformatf("vec%0d_fwdA", i), {30'd0, forwardAE}, {30'd0, vecs[i].fa});
      chk($sformatf("vec%0d_fwdB", i), {30'd0, forwardBE}, {30'd0, vecs[i].fb});
      step();
    end

    // Issue rd=9, then a dependent read stalls until the completion releases it.
    clear_inputs();
    long_op(5'd9);
    #1;
    chk("issue9_nostall", {31'd0, stallD}, 32'd0);
    step();
    clear_inputs();
    validD = 1; useRs1D = 1; rs1D = 5'd9;
    #1;
    chk("pending9_set", {31'd0, pending[9]}, 32'd1);
    chk("dep9_stall", {31'd0, stallD}, 32'd1);
    chk("dep9_flushE", {31'd0, flushE}, 32'd1);
    step();
    doneValid = 1; doneRd = 5'd9;
    #1;
`ifdef HAZARD_SB_DONE_BYPASS_EN
    chk("done9_release", {31'd0, stallD}, 32'd0);
`else
    chk("done9_release", {31'd0, stallD}, 32'd1);
`endif
    step();
    doneValid = 0;
    #1;
    chk("after9_stall", {31'd0, stallD}, 32'd0);
    chk("pending9_clr", {31'd0, pending[9]}, 32'd0);
    chk("count_after9", {29'd0, dut.u_sb.count}, 32'd0);
    step();

    // Fill the outstanding budget with rd 1..4; the fifth long op stalls.
    clear_inputs();
    for (int r = 1; r <= 4; r++) begin
      long_op(5'(r));
      #1;
      chk($sformatf("fill%0d_nostall", r), {31'd0, stallD}, 32'd0);
      step();
    end
    long_op(5'd5);
    #1;
    chk("full_stall", {31'd0, stallD}, 32'd1);
    chk("full_count", {29'd0, dut.u_sb.count}, 32'd4);
    step();
    doneValid = 1; doneRd = 5'd1;
    #1;
`ifdef HAZARD_SB_DONE_BYPASS_EN
    chk("done_issue_stall", {31'd0, stallD}, 32'd0);
`else
    chk("done_issue_stall", {31'd0, stallD}, 32'd1);
`endif
    step();
    doneValid = 0;
    #1;
`ifdef HAZARD_SB_DONE_BYPASS_EN
    chk("retry_stall", {31'd0, stallD}, 32'd1);
    chk("count_held", {29'd0, dut.u_sb.count}, 32'd4);
`else
    chk("retry_stall", {31'd0, stallD}, 32'd0);
    chk("count_dec", {29'd0, dut.u_sb.count}, 32'd3);
`endif
    step();
    clear_inputs();
    #1;
    chk("fill_count", {29'd0, dut.u_sb.count}, 32'd4);
    chk("fill_pending", pending, 32'h0000_003C);

    // Spurious completion: sticky error, count and pending unchanged.
    doneValid = 1; doneRd = 5'd12;
    #1;
    chk("sberr_before", {31'd0, sbError}, 32'd0);
    step();
    doneValid = 0;
    #1;
    chk("sberr_set", {31'd0, sbError}, 32'd1);
    chk("sberr_count", {29'd0, dut.u_sb.count}, 32'd4);
    chk("sberr_pending", pending, 32'h0000_003C);
    step();
    chk("sberr_sticky", {31'd0, sbError}, 32'd1);

    // Asynchronous reset mid-run clears everything at once.
    #2;
    rst_n = 0;
    #1;
    chk("arst_pending", pending, 32'h0);
    chk("arst_count", {29'd0, dut.u_sb.count}, 32'd0);
    chk("arst_sberr", {31'd0, sbError}, 32'd0);
    chk("arst_ctrl", {26'd0, stallF, stallD, flushD, flushE, forwardAE}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    step();
    long_op(5'd3);
    step();
    clear_inputs();
    #1;
    chk("post_rst_issue", pending, 32'h0000_0008);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
